blink_monitor: RTL and testbench

Receive-side checker for the health-indicator blink line. Samples a blinking input (normally the LED line produced by the blinker output driver, looped back or tapped), measures the time between consecutive toggles, and reports whether the line is blinking at the expected rate, stuck, or toggling too fast. Sits beside the blinker driver as its self-check partner and feeds the top-level health status.

---
 rtl/blink_monitor.sv | 154 +++++++++++++++
 tb/tb_blink_monitor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/blink_monitor.sv
// Receive-side checker for the health blink line: measures the interval between
// toggles and reports lock (healthy), stuck line or out-of-window toggle rate.
module blink_monitor #(
  parameter int MIN_HALF   = 3,
  parameter int MAX_HALF   = 5,
  parameter int LOCK_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blink_in,
  output logic             healthy,
  output logic             stuck_fault,
  output logic             rate_fault,
  output logic [CNT_W-1:0] half_period,
  output logic             half_valid
);

  localparam int G_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_HALF);
  localparam logic [G_W-1:0]   LOCK_C = G_W'(LOCK_COUNT);

  typedef enum logic [1:0] {SEARCH, TRACK, HEALTHY, FAULT} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [G_W-1:0]   g_q, g_d;
  logic             seen_q, seen_d;
  logic             stuck_q, stuck_d;
  logic             rate_q, rate_d;
  logic             healthy_q, healthy_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic             hv_q, hv_d;

  logic edge_ev, legal, timeout;

  assign edge_ev = s2_q ^ s3_q;
  assign legal   = (cnt_q >= MIN_C) && (cnt_q <= MAX_C);
  // An edge on the timeout cycle is judged as a (too long) interval, not as stuck.
  assign timeout = !edge_ev && (cnt_q > MAX_C);

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    seen_d  = seen_q;
    stuck_d = stuck_q;
    rate_d  = rate_q;
    hp_d    = hp_q;
    hv_d    = 1'b0;
    cnt_d   = edge_ev ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);

    // The first edge after reset has no preceding edge, so nothing is reported.
    if (edge_ev) begin
      seen_d = 1'b1;
      if (seen_q) begin
        hv_d = 1'b1;
        hp_d = cnt_q;
      end
    end

    case (state_q)
      SEARCH: begin
        if (edge_ev) begin
          state_d = TRACK;
          g_d     = '0;
        end else if (timeout) begin
          state_d = FAULT;
          stuck_d = 1'b1;
        end
      end
      TRACK: begin
        if (edge_ev) begin
          if (legal) begin
            g_d = g_q + 1'b1;
            if (g_q + 1'b1 == LOCK_C) state_d = HEALTHY;
          end else begin
            state_d = FAULT;
            rate_d  = 1'b1;
          end
        end else if (timeout) begin
          state_d = FAULT;
          stuck_d = 1'b1;
        end
      end
      HEALTHY: begin
        if (edge_ev && !legal) begin
          state_d = FAULT;
          rate_d  = 1'b1;
        end else if (timeout) begin
          state_d = FAULT;
          stuck_d = 1'b1;
        end
      end
      FAULT: begin
        if (edge_ev) begin
          if (legal) begin
            g_d     = G_W'(1);
            state_d = (LOCK_COUNT == 1) ? HEALTHY : TRACK;
          end else begin
            rate_d = 1'b1;
          end
        end else if (timeout) begin
          stuck_d = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase

    if (state_d == HEALTHY && state_q != HEALTHY) begin
      stuck_d = 1'b0;
      rate_d  = 1'b0;
    end
    healthy_d = (state_d == HEALTHY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      state_q   <= SEARCH;
      cnt_q     <= '0;
      g_q       <= '0;
      seen_q    <= 1'b0;
      stuck_q   <= 1'b0;
      rate_q    <= 1'b0;
      healthy_q <= 1'b0;
      hp_q      <= '0;
      hv_q      <= 1'b0;
    end else begin
      s1_q      <= blink_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      g_q       <= g_d;
      seen_q    <= seen_d;
      stuck_q   <= stuck_d;
      rate_q    <= rate_d;
      healthy_q <= healthy_d;
      hp_q      <= hp_d;
      hv_q      <= hv_d;
    end
  end

  assign healthy     = healthy_q;
  assign stuck_fault = stuck_q;
  assign rate_fault  = rate_q;
  assign half_period = hp_q;
  assign half_valid  = hv_q;

endmodule

// File: tb/tb_blink_monitor.sv
// Bench for blink_monitor: directed scenarios followed by random toggle intervals,
// every cycle compared against a cycle-numbered event model of the monitor.
module tb_blink_monitor;

  localparam int MIN_HALF   = 3;
  localparam int MAX_HALF   = 5;
  localparam int LOCK_COUNT = 3;
  localparam int CNT_W      = 16;
  localparam int SAT        = (1 << CNT_W) - 1;

  localparam int M_SEARCH  = 0;
  localparam int M_TRACK   = 1;
  localparam int M_HEALTHY = 2;
  localparam int M_FAULT   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             blink_in;
  logic             healthy, stuck_fault, rate_fault, half_valid;
  logic [CNT_W-1:0] half_period;

  always #5 clk = ~clk;

  blink_monitor #(
    .MIN_HALF(MIN_HALF), .MAX_HALF(MAX_HALF), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .blink_in(blink_in),
    .healthy(healthy), .stuck_fault(stuck_fault), .rate_fault(rate_fault),
    .half_period(half_period), .half_valid(half_valid)
  );

  int n_vec = 0;
  int n_mis = 0;

  // Model: times are posedge numbers; last_ev is the cycle of the last edge event
  // (or the first cycle after reset), so the running interval is cyc - last_ev.
  int cyc = 0;
  int last_ev = 0;
  int mode = M_SEARCH;
  int good = 0;
  int m_hp = 0;
  bit m_hv = 0, m_stuck = 0, m_rate = 0, m_seen = 0;
  bit smp0 = 0, smp1 = 0, smp2 = 0;   // blink_in sampled 1, 2, 3 posedges ago

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic go_healthy();
    mode    = M_HEALTHY;
    m_stuck = 0;
    m_rate  = 0;
  endtask

  task automatic model_step();
    bit ev, lg;
    int n;
    cyc++;
    if (rst) begin
      mode = M_SEARCH; good = 0; m_hp = 0; m_hv = 0;
      m_stuck = 0; m_rate = 0; m_seen = 0;
      last_ev = cyc + 1;
      smp0 = 0; smp1 = 0; smp2 = 0;
    end else begin
      // Synchronizer delay: the line change sampled at posedge p becomes an
      // edge event in the cycle ending at posedge p+2.
      ev   = (smp1 != smp2);
      n    = cyc - last_ev;
      if (n > SAT) n = SAT;
      lg   = (n >= MIN_HALF) && (n <= MAX_HALF);
      m_hv = 0;
      if (ev) begin
        if (m_seen) begin
          m_hv = 1;
          m_hp = n;
        end
        m_seen  = 1;
        last_ev = cyc;
        case (mode)
          M_SEARCH: begin mode = M_TRACK; good = 0; end
          M_TRACK: begin
            if (lg) begin
              good++;
              if (good == LOCK_COUNT) go_healthy();
            end else begin
              mode = M_FAULT; m_rate = 1;
            end
          end
          M_HEALTHY: if (!lg) begin mode = M_FAULT; m_rate = 1; end
          default: begin
            if (lg) begin
              good = 1;
              if (LOCK_COUNT == 1) go_healthy(); else mode = M_TRACK;
            end else m_rate = 1;
          end
        endcase
      end else if (n > MAX_HALF) begin
        mode    = M_FAULT;
        m_stuck = 1;
      end
      smp2 = smp1; smp1 = smp0; smp0 = blink_in;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("healthy",     32'(healthy),     32'(mode == M_HEALTHY));
    chk("stuck_fault", 32'(stuck_fault), 32'(m_stuck));
    chk("rate_fault",  32'(rate_fault),  32'(m_rate));
    chk("half_valid",  32'(half_valid),  32'(m_hv));
    chk("half_period", 32'(half_period), 32'(m_hp));
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic toggle_every(input int l, input int count);
    repeat (count) begin
      blink_in = ~blink_in;
      hold(l);
    end
  endtask

  int seq_a[6] = '{3, 5, 3, 5, 4, 6};
  int seq_b[5] = '{4, 4, 4, 4, 2};

  initial begin
    rst      = 1'b1;
    blink_in = 1'b0;
    repeat (3) begin
      blink_in = ~blink_in;
      step();
    end
    rst = 1'b0;
    hold(2);

    // Lock at period 4, stall into a stuck fault, then recover.
    toggle_every(4, 6);
    hold(10);
    toggle_every(4, 6);

    // Window boundaries, then a too-fast toggle from healthy.
    foreach (seq_a[i]) toggle_every(seq_a[i], 1);
    toggle_every(4, 5);
    foreach (seq_b[i]) toggle_every(seq_b[i], 1);

    // Reset in the middle of a locked stream.
    toggle_every(4, 5);
    rst = 1'b1;
    blink_in = ~blink_in;
    step();
    rst = 1'b0;
    hold(3);

    // Random intervals biased around the legal window, with long holds and resets.
    repeat (400) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        rst = 1'b1;
        if ($urandom_range(0, 1) == 1) blink_in = ~blink_in;
        hold(int'($urandom_range(1, 3)));
        rst = 1'b0;
      end else if (r < 3) begin
        toggle_every(int'($urandom_range(7, 14)), 1);
      end else if (r < 5) begin
        toggle_every(int'($urandom_range(1, 2)), 1);
      end else begin
        toggle_every(int'($urandom_range(MIN_HALF, MAX_HALF + 1)), 1);
      end
    end
    hold(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
